// File: rtl/wb_select_pipe_if.sv
// Handshake bundle for wb_select_pipe: sources/selector in, registered result out.
// The ext_mode signal exists only when WB_LOAD_EXT_EN is defined.
interface wb_select_pipe_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 9,
    parameter int SEL_W   = 4
);
    logic [NUM_SRC*WIDTH-1:0] src_flat;
    logic [SEL_W-1:0]         sel;
    logic                     in_valid;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_sel_err;
`ifdef WB_LOAD_EXT_EN
    logic [2:0]               ext_mode;

    modport master (
        output src_flat, sel, in_valid, out_ready, ext_mode,
        input  in_ready, out_valid, out_data, out_sel_err
    );
    modport slave (
        input  src_flat, sel, in_valid, out_ready, ext_mode,
        output in_ready, out_valid, out_data, out_sel_err
    );
`else
    modport master (
        output src_flat, sel, in_valid, out_ready,
        input  in_ready, out_valid, out_data, out_sel_err
    );
    modport slave (
        input  src_flat, sel, in_valid, out_ready,
        output in_ready, out_valid, out_data, out_sel_err
    );
`endif
endinterface

// File: rtl/wb_select_pipe.sv
// Write-back source selector with a registered output and a 2-entry skid buffer.
// Define WB_LOAD_EXT_EN to add load sign/zero extension driven by ext_mode.
module wb_select_pipe #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 9,
    parameter int SEL_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    wb_select_pipe_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_SKID  = 1'b1
    } skid_state_t;

    skid_state_t      state_r;
    skid_state_t      state_s;

    logic [WIDTH-1:0] src_arr_s [NUM_SRC];
    logic [WIDTH-1:0] acc_s     [NUM_SRC+1];
    logic [NUM_SRC-1:0] hit_s;
    logic             sel_ok_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [WIDTH-1:0] new_data_s;
    logic             new_err_s;

    logic             main_valid_r;
    logic [WIDTH-1:0] main_data_r;
    logic             main_err_r;
    logic [WIDTH-1:0] skid_data_r;
    logic             skid_err_r;
    logic             in_ready_r;

    logic             accept_s;
    logic             xfer_s;
    logic             load_new_s;
    logic             load_skid_s;
    logic             move_skid_s;
    logic             drain_s;

`ifdef WB_LOAD_EXT_EN
    function automatic logic [WIDTH-1:0] load_ext(input logic [WIDTH-1:0] v, input logic [2:0] mode);
        case (mode)
            3'b001:  return {{(WIDTH-8){v[7]}}, v[7:0]};
            3'b010:  return {{(WIDTH-8){1'b0}}, v[7:0]};
            3'b011:  return {{(WIDTH-16){v[15]}}, v[15:0]};
            3'b100:  return {{(WIDTH-16){1'b0}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic ext_mode_err(input logic [2:0] mode);
        return (mode > 3'b100);
    endfunction
`endif

    // One-hot decode of sel, then an AND-OR chain so no runtime indexing is needed.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_mux
        assign src_arr_s[g] = bus.src_flat[g*WIDTH +: WIDTH];
        assign hit_s[g]     = ({1'b0, bus.sel} == (SEL_W+1)'(g));
        assign acc_s[g+1]   = acc_s[g] | (src_arr_s[g] & {WIDTH{hit_s[g]}});
    end
    assign acc_s[0]   = {WIDTH{1'b0}};
    assign sel_ok_s   = |hit_s;
    // Out-of-range codes fall back to the last source, as legacy software expects.
    assign sel_data_s = sel_ok_s ? acc_s[NUM_SRC] : src_arr_s[NUM_SRC-1];

`ifdef WB_LOAD_EXT_EN
    assign new_data_s = load_ext(sel_data_s, bus.ext_mode);
    assign new_err_s  = ~sel_ok_s | ext_mode_err(bus.ext_mode);
`else
    assign new_data_s = sel_data_s;
    assign new_err_s  = ~sel_ok_s;
`endif

    assign accept_s = bus.in_valid & in_ready_r;
    assign xfer_s   = main_valid_r & bus.out_ready;

    // Skid state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and storage control: main reloads whenever it is empty or being drained.
    always_comb begin
        state_s     = state_r;
        load_new_s  = 1'b0;
        load_skid_s = 1'b0;
        move_skid_s = 1'b0;
        drain_s     = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    if (main_valid_r && !bus.out_ready) begin
                        load_skid_s = 1'b1;
                        state_s     = ST_SKID;
                    end else begin
                        load_new_s  = 1'b1;
                    end
                end else begin
                    drain_s = xfer_s;
                end
            end
            ST_SKID: begin
                if (bus.out_ready) begin
                    move_skid_s = 1'b1;
                    state_s     = ST_EMPTY;
                end else begin
                    state_s     = ST_SKID;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
    end

    // Main output register; data holds its last value once drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_r <= 1'b0;
            main_data_r  <= {WIDTH{1'b0}};
            main_err_r   <= 1'b0;
        end else if (load_new_s) begin
            main_valid_r <= 1'b1;
            main_data_r  <= new_data_s;
            main_err_r   <= new_err_s;
        end else if (move_skid_s) begin
            main_valid_r <= 1'b1;
            main_data_r  <= skid_data_r;
            main_err_r   <= skid_err_r;
        end else if (drain_s) begin
            main_valid_r <= 1'b0;
        end
    end

    // Skid register and registered ready (ready only while the skid slot is free).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_data_r <= {WIDTH{1'b0}};
            skid_err_r  <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            if (load_skid_s) begin
                skid_data_r <= new_data_s;
                skid_err_r  <= new_err_s;
            end
            in_ready_r <= (state_s == ST_EMPTY);
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = main_valid_r;
    assign bus.out_data    = main_data_r;
    assign bus.out_sel_err = main_err_r;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Randomised and directed bench for wb_select_pipe against a queue-based reference model.
// Define WB_LOAD_EXT_EN to also exercise load extension.
module tb_wb_select_pipe;
    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 9;
    localparam int SEL_W   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_select_pipe_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

    wb_select_pipe #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];          // {err, data} of accepted, not yet delivered results
    logic [31:0] src [NUM_SRC];

    task automatic check_eq(input string tag, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference result straight from the selection / extension rules.
    function automatic logic [32:0] model(input logic [3:0] s, input logic [2:0] em);
        int          idx;
        logic        err;
        logic [31:0] v;
        if (int'(s) < NUM_SRC) begin
            idx = int'(s);
            err = 1'b0;
        end else begin
            idx = NUM_SRC - 1;
            err = 1'b1;
        end
        v = src[idx];
`ifdef WB_LOAD_EXT_EN
        case (em)
            3'd1: v = (v & 32'hFF) | ((v & 32'h80) != 0 ? 32'hFFFF_FF00 : 32'h0);
            3'd2: v = v & 32'hFF;
            3'd3: v = (v & 32'hFFFF) | ((v & 32'h8000) != 0 ? 32'hFFFF_0000 : 32'h0);
            3'd4: v = v & 32'hFFFF;
            3'd5, 3'd6, 3'd7: err = 1'b1;
            default: v = v;
        endcase
`else
        if (em != 3'd0) v = v;
`endif
        return {err, v};
    endfunction

    task automatic check_outputs();
        check_eq("in_ready",  {32'd0, bus.in_ready},  {32'd0, (exp_q.size() < 2)});
        check_eq("out_valid", {32'd0, bus.out_valid}, {32'd0, (exp_q.size() > 0)});
        if (exp_q.size() > 0)
            check_eq("out_data", {bus.out_sel_err, bus.out_data}, exp_q[0]);
    endtask

    // Called at a falling edge: check, drive, advance one clock, update model.
    task automatic step(input logic v, input logic [3:0] s, input logic ordy, input logic [2:0] em);
        logic        acc;
        logic        xf;
        logic [32:0] e;
        check_outputs();
        bus.in_valid  = v;
        bus.sel       = s;
        bus.out_ready = ordy;
        for (int i = 0; i < NUM_SRC; i++) bus.src_flat[i*WIDTH +: WIDTH] = src[i];
`ifdef WB_LOAD_EXT_EN
        bus.ext_mode = em;
`endif
        acc = v && (exp_q.size() < 2);
        xf  = ordy && (exp_q.size() > 0);
        e   = model(s, em);
        @(posedge clk);
        if (xf)  void'(exp_q.pop_front());
        if (acc) exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b1, 3'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sel       = 4'd0;
        bus.out_ready = 1'b0;
        bus.src_flat  = '0;
`ifdef WB_LOAD_EXT_EN
        bus.ext_mode  = 3'd0;
`endif
        for (int i = 0; i < NUM_SRC; i++) src[i] = 32'hA000_0000 + 32'(i);
        repeat (2) @(negedge clk);
        check_eq("rst_valid", {32'd0, bus.out_valid}, 33'd0);
        check_eq("rst_data",  {bus.out_sel_err, bus.out_data}, 33'd0);
        check_eq("rst_ready", {32'd0, bus.in_ready}, 33'd1);
        reset = 1'b0;
        @(negedge clk);

        // Select sweep including an out-of-range code.
        for (int i = 0; i < NUM_SRC; i++) step(1'b1, 4'(i), 1'b1, 3'd0);
        step(1'b1, 4'hF, 1'b1, 3'd0);
        check_eq("sel_oob", {bus.out_sel_err, bus.out_data}, {1'b1, 32'hA000_0008});
        drain();

        // Stall: two accepts fill both entries, third is held off.
        step(1'b1, 4'd1, 1'b0, 3'd0);
        step(1'b1, 4'd2, 1'b0, 3'd0);
        check_eq("stall_ready", {32'd0, bus.in_ready}, 33'd0);
        step(1'b1, 4'd3, 1'b0, 3'd0);
        step(1'b1, 4'd3, 1'b0, 3'd0);
        check_eq("stall_hold", {bus.out_sel_err, bus.out_data}, {1'b0, 32'hA000_0001});
        step(1'b0, 4'd0, 1'b1, 3'd0);
        check_eq("stall_second", {bus.out_sel_err, bus.out_data}, {1'b0, 32'hA000_0002});
        drain();

        // Back-to-back stream of 16 results.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < NUM_SRC; i++) src[i] = $urandom;
            step(1'b1, 4'($urandom_range(0, 15)), 1'b1, 3'd0);
        end
        drain();

        // Random valid/ready toggling.
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < NUM_SRC; i++) src[i] = $urandom;
`ifdef WB_LOAD_EXT_EN
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)));
`else
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 3'd0);
`endif
        end
        drain();

`ifdef WB_LOAD_EXT_EN
        src[0] = 32'h0000_8081;
        step(1'b1, 4'd0, 1'b1, 3'd1);
        check_eq("ext_lb",  {bus.out_sel_err, bus.out_data}, {1'b0, 32'hFFFF_FF81});
        step(1'b1, 4'd0, 1'b1, 3'd2);
        check_eq("ext_lbu", {bus.out_sel_err, bus.out_data}, {1'b0, 32'h0000_0081});
        step(1'b1, 4'd0, 1'b1, 3'd3);
        check_eq("ext_lh",  {bus.out_sel_err, bus.out_data}, {1'b0, 32'hFFFF_8081});
        step(1'b1, 4'd0, 1'b1, 3'd4);
        check_eq("ext_lhu", {bus.out_sel_err, bus.out_data}, {1'b0, 32'h0000_8081});
        step(1'b1, 4'd0, 1'b1, 3'd7);
        check_eq("ext_bad", {bus.out_sel_err, bus.out_data}, {1'b1, 32'h0000_8081});
        drain();
`endif

        // Reset mid-stall with both entries occupied.
        step(1'b1, 4'd5, 1'b0, 3'd0);
        step(1'b1, 4'd6, 1'b0, 3'd0);
        check_eq("pre_rst_ready", {32'd0, bus.in_ready}, 33'd0);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", {32'd0, bus.out_valid}, 33'd0);
        check_eq("mid_rst_data",  {bus.out_sel_err, bus.out_data}, 33'd0);
        check_eq("mid_rst_ready", {32'd0, bus.in_ready}, 33'd1);
        exp_q.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        step(1'b1, 4'd7, 1'b1, 3'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
